// File: rtl/vedm_industries.sv
// Source conditioner and data logger: input sampling, IIR low-pass filter, voltage window flags,
// slow duty-cycle regulation of a PWM gate, and a saturating energy accumulator with an output mux.
module vedm_industries (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [15:0] TARGET = 16'd8192;

  logic [7:0]        s;
  logic [7:0]        f;
  logic [7:0]        cnt;
  logic [7:0]        d;
  logic [23:0]       acc;
  logic              pwm_q;

  logic              uv;
  logic              ov;
  logic              ok;
  logic signed [8:0] diff;
  logic signed [8:0] step;
  logic [8:0]        f_sum;
  logic [7:0]        f_next;
  logic [15:0]       p;
  logic [7:0]        d_next;
  logic [24:0]       acc_sum;
  logic [7:0]        mux;
  logic              unused_bits;

  assign uio_out     = 8'h00;
  assign uio_oe      = 8'h00;
  assign unused_bits = ^{uio_in[7:2], f_sum[8]};

  always_comb begin
    // Floor shift lets a falling input pull f all the way down to s.
    diff    = $signed({1'b0, s}) - $signed({1'b0, f});
    step    = diff >>> 2;
    f_sum   = {1'b0, f} + step;
    f_next  = f_sum[7:0];

    uv      = (f < 8'd32);
    ov      = (f > 8'd224);
    ok      = !uv && !ov;

    p       = {8'h00, f} * {8'h00, d};
    acc_sum = {1'b0, acc} + {17'h00000, s};

    d_next  = d;
    if (cnt == 8'hFF && ok) begin
      if (p > TARGET && d != 8'h00) begin
        d_next = d - 8'd1;
      end else if (p < TARGET && d != 8'hFF) begin
        d_next = d + 8'd1;
      end
    end

    mux = 8'h00;
    case (uio_in[1:0])
      2'd0: mux = {f[7:4], ok, ov, uv, pwm_q};
      2'd1: mux = d;
      2'd2: mux = f;
      2'd3: mux = acc[23:16];
      default: mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s      <= 8'h00;
      f      <= 8'h00;
      cnt    <= 8'h00;
      d      <= 8'h80;
      acc    <= 24'h000000;
      pwm_q  <= 1'b0;
      uo_out <= 8'h00;
    end else begin
      s      <= ui_in;
      f      <= f_next;
      cnt    <= cnt + 8'd1;
      d      <= d_next;
      acc    <= acc_sum[24] ? 24'hFFFFFF : acc_sum[23:0];
      pwm_q  <= ok && (cnt < d);
      uo_out <= mux;
    end
  end

endmodule

// File: tb/tb_vedm_industries.sv
// Directed bench for vedm_industries: reset, filter step, regulation, PWM duty, over-voltage freeze,
// accumulator saturation, recovery to a low input and mid-run reset.
module tb_vedm_industries;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  vedm_industries dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; sampling and driving happen 1 ns after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic go_to(input int e);
    while (edge_n < e) tick(1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  initial begin
    int highs;
    int mono_bad;
    logic [7:0] prev;

    rst_n  = 1'b0;
    ui_in  = 8'd150;
    uio_in = 8'h01;
    tick(2);
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);

    rst_n  = 1'b1;
    edge_n = 0;
    tick(1);
    chk("rel_d", uo_out, 8'h80);

    uio_in = 8'h00;
    tick(1);
    chk("flags_uv", uo_out, 8'h02);

    uio_in = 8'h02;
    tick(1);
    chk("filt_e3", uo_out, 8'd37);
    tick(1);
    chk("filt_e4", uo_out, 8'd65);
    tick(1);
    chk("filt_e5", uo_out, 8'd86);
    mono_bad = 0;
    prev = uo_out;
    while (edge_n < 40) begin
      tick(1);
      if (uo_out < prev) mono_bad++;
      prev = uo_out;
    end
    chk("filt_mono", mono_bad, 0);
    chk("filt_settle", uo_out, 8'd147);

    uio_in = 8'h00;
    tick(1);
    chk("flags_ok_147", uo_out[7:1], 7'h4C);

    // Overshoot then fall back so f lands exactly on 150 before the first regulation edge.
    ui_in = 8'd255;
    go_to(70);
    ui_in  = 8'd150;
    uio_in = 8'h01;
    go_to(256);
    chk("reg_pre_first", uo_out, 8'h80);
    tick(1);
    chk("reg_first_step", uo_out, 8'h7F);
    go_to(513);
    chk("reg_second_step", uo_out, 8'h7E);
    go_to(18689);
    chk("reg_k73", uo_out, 8'd55);
    go_to(18945);
    chk("reg_k74", uo_out, 8'd54);
    go_to(19201);
    chk("reg_k75", uo_out, 8'd55);
    go_to(19457);
    chk("reg_k76", uo_out, 8'd54);

    uio_in = 8'h00;
    highs = 0;
    repeat (256) begin
      tick(1);
      if (uo_out[0]) highs++;
    end
    chk("pwm_duty_54", highs, 54);
    chk("pwm_flags", uo_out[7:1], 7'h4C);

    ui_in = 8'd240;
    go_to(20000);
    chk("ov_flags", uo_out, 8'hE4);
    highs = 0;
    repeat (256) begin
      tick(1);
      if (uo_out[0]) highs++;
    end
    chk("ov_pwm_off", highs, 0);
    uio_in = 8'h01;
    tick(1);
    chk("ov_d_frozen", uo_out, 8'd55);

    uio_in = 8'h03;
    go_to(80000);
    chk("acc_sat", uo_out, 8'hFF);
    go_to(83000);
    chk("acc_hold", uo_out, 8'hFF);
    uio_in = 8'h01;
    tick(1);
    chk("ov_d_still", uo_out, 8'd55);

    ui_in  = 8'd45;
    uio_in = 8'h00;
    go_to(83100);
    chk("flags_45", uo_out, 8'h28);
    uio_in = 8'h01;
    go_to(83201);
    chk("climb_1", uo_out, 8'd56);
    go_to(83457);
    chk("climb_2", uo_out, 8'd57);

    rst_n = 1'b0;
    tick(1);
    chk("midrst_uo_out", uo_out, 8'h00);
    rst_n = 1'b1;
    tick(1);
    chk("midrst_d", uo_out, 8'h80);
    uio_in = 8'h03;
    tick(1);
    chk("midrst_acc", uo_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
